// File: rtl/i2_group_scan_ctrl.sv
// i2_group_scan_ctrl
//
// Scans NUM_GROUPS groups of a wide input vector through a single shared
// GROUP_W-wide OR reducer, one group per cycle. A start handshake captures
// the vector and a per-group enable mask. Each group's result lands in
// hit_grp_o. The combined hit_o is reported after the done_o pulse.
//
// Optional feature macro: I2_SCAN_EARLY_EXIT_EN
//   When it is defined, the scan stops after the first group that hits.
//   When it is undefined, every group is always scanned.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start_i     in   request a scan; accepted only when idle
//   vec_i       in   NUM_GROUPS*GROUP_W input vector, group k at [k*GROUP_W +: GROUP_W]
//   grp_en_i    in   per-group participation mask
//   busy_o      out  high while scanning and during the done cycle
//   done_o      out  one-cycle completion pulse
//   hit_o       out  OR of all per-group hits of the last completed scan
//   hit_grp_o   out  per-group hits of the last completed scan
//   scan_idx_o  out  index of the group currently being reduced
module i2_group_scan_ctrl #(
  parameter int GROUP_W    = 32,
  parameter int NUM_GROUPS = 4,
  localparam int IDX_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [NUM_GROUPS*GROUP_W-1:0] vec_i,
  input  logic [NUM_GROUPS-1:0]         grp_en_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          hit_o,
  output logic [NUM_GROUPS-1:0]         hit_grp_o,
  output logic [IDX_W-1:0]              scan_idx_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef I2_SCAN_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);

  logic [1:0]                  state_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [NUM_GROUPS*GROUP_W-1:0] vec_reg;
  logic [NUM_GROUPS-1:0]       en_reg;
  logic [NUM_GROUPS-1:0]       hit_grp_reg;
  logic                        hit_reg;
  logic                        busy_reg;
  logic                        done_reg;

  // Split the captured vector into groups so that the shared reducer can
  // select one group by index.
  logic [GROUP_W-1:0] groups [NUM_GROUPS];

  generate
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_split
      assign groups[gi] = vec_reg[gi*GROUP_W +: GROUP_W];
    end
  endgenerate

  // This is the single shared reducer. A disabled group still takes its
  // cycle, but it can only report 0.
  logic group_hit;
  assign group_hit = en_reg[idx_reg] & (|groups[idx_reg]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      vec_reg     <= '0;
      en_reg      <= '0;
      hit_grp_reg <= '0;
      hit_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start_i) begin
            vec_reg     <= vec_i;
            en_reg      <= grp_en_i;
            hit_grp_reg <= '0;
            hit_reg     <= 1'b0;
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          hit_grp_reg[idx_reg] <= group_hit;
          // The index stops at the last group that was reduced. It never wraps.
          if (idx_reg == LAST_IDX || (EARLY_EXIT && group_hit)) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_DONE: begin
          // hit_grp_reg already holds the result for the last reduced group.
          hit_reg   <= |hit_grp_reg;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign hit_o      = hit_reg;
  assign hit_grp_o  = hit_grp_reg;
  assign scan_idx_o = idx_reg;

endmodule

// File: tb/tb_i2_group_scan_ctrl.sv
// Self-checking bench for i2_group_scan_ctrl with the default parameters
// (GROUP_W=32, NUM_GROUPS=4). The expected results follow the
// I2_SCAN_EARLY_EXIT_EN setting of the build.
module tb_i2_group_scan_ctrl;

  localparam int GW = 32;
  localparam int NG = 4;
  localparam int VW = GW * NG;

`ifdef I2_SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [VW-1:0] vec_i = '0;
  logic [NG-1:0] grp_en_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          hit_o;
  logic [NG-1:0] hit_grp_o;
  logic [1:0]    scan_idx_o;

  i2_group_scan_ctrl #(.GROUP_W(GW), .NUM_GROUPS(NG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .vec_i      (vec_i),
    .grp_en_i   (grp_en_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hit_o      (hit_o),
    .hit_grp_o  (hit_grp_o),
    .scan_idx_o (scan_idx_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_scan   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: OR every bit of each group and mask the result with
  // the enable bit. When early exit is on, the scan stops at the first
  // group that hits. The result is the hit vector and the number of
  // clock edges from accept to done.
  function automatic void model(input logic [VW-1:0] v, input logic [NG-1:0] en,
                                output logic [NG-1:0] g, output int edges);
    logic any;
    g = '0;
    edges = NG;
    for (int k = 0; k < NG; k++) begin
      any = 1'b0;
      for (int b = 0; b < GW; b++) any = any | v[k*GW + b];
      g[k] = en[k] & any;
      if (EARLY && g[k]) begin
        edges = k + 1;
        break;
      end
    end
  endfunction

  function automatic logic [VW-1:0] bits2(input int a, input int b);
    logic [VW-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  // This task is entered at the negedge right after the accept edge. It
  // follows the scan through to the cycle after done_o.
  task automatic finish_scan(input string tag, input logic [NG-1:0] exp_grp, input int exp_edges);
    int e;
    e = 0;
    check({tag, "_busy_acc"}, 32'(busy_o), 32'd1);
    check({tag, "_idx_acc"}, 32'(scan_idx_o), 32'd0);
    check({tag, "_hit_clr"}, 32'(hit_o), 32'd0);
    check({tag, "_done_acc"}, 32'(done_o), 32'd0);
    while (!done_o && e < NG + 3) begin
      @(negedge clk);
      e++;
      if (!done_o) check({tag, "_idx"}, 32'(scan_idx_o), 32'(e));
    end
    check({tag, "_latency"}, 32'(e), 32'(exp_edges));
    check({tag, "_hit_grp"}, 32'(hit_grp_o), 32'(exp_grp));
    check({tag, "_busy_done"}, 32'(busy_o), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    check({tag, "_hit"}, 32'(hit_o), 32'(|exp_grp));
    check({tag, "_hit_grp_hold"}, 32'(hit_grp_o), 32'(exp_grp));
    n_scan++;
    $display("scan %0d %s: en=%b hit_grp=%b hit=%b edges=%0d", n_scan, tag,
             grp_en_i, hit_grp_o, hit_o, e);
  endtask

  // This task is entered at a negedge while the DUT is idle. After the
  // capture edge it drives inverted inputs to show that they have no effect.
  task automatic run_scan(input string tag, input logic [VW-1:0] v, input logic [NG-1:0] en,
                          input logic [NG-1:0] exp_grp, input int exp_edges);
    start_i  = 1'b1;
    vec_i    = v;
    grp_en_i = en;
    @(negedge clk);
    start_i  = 1'b0;
    vec_i    = ~v;
    grp_en_i = ~en;
    finish_scan(tag, exp_grp, exp_edges);
  endtask

  typedef struct {
    logic [VW-1:0] vec;
    logic [NG-1:0] en;
    logic [NG-1:0] grp_full;
    int            edges_full;
    logic [NG-1:0] grp_early;
    int            edges_early;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] ones;
    logic [VW-1:0] v;
    logic [NG-1:0] en;
    logic [NG-1:0] g;
    int            edges;
    int            exp_e;

    ones = '1;
    tbl[0] = '{bits2(70, -1),  4'b1111, 4'b0100, 4, 4'b0100, 3};
    tbl[1] = '{bits2(5, 100),  4'b0110, 4'b0000, 4, 4'b0000, 4};
    tbl[2] = '{ones,           4'b1111, 4'b1111, 4, 4'b0001, 1};
    tbl[3] = '{ones,           4'b0000, 4'b0000, 4, 4'b0000, 4};
    tbl[4] = '{bits2(-1, -1),  4'b1111, 4'b0000, 4, 4'b0000, 4};
    tbl[5] = '{bits2(31, 96),  4'b1001, 4'b1001, 4, 4'b0001, 1};
    tbl[6] = '{bits2(127, -1), 4'b1000, 4'b1000, 4, 4'b1000, 4};
    tbl[7] = '{bits2(32, 64),  4'b0100, 4'b0100, 4, 4'b0100, 3};

    // Hold reset with start asserted. All outputs must stay at zero.
    rst_n    = 1'b0;
    start_i  = 1'b1;
    vec_i    = ones;
    grp_en_i = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_hit", 32'(hit_o), 32'd0);
    check("rst_hit_grp", 32'(hit_grp_o), 32'd0);
    check("rst_idx", 32'(scan_idx_o), 32'd0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done_o), 32'd0);
      check("post_rst_busy", 32'(busy_o), 32'd0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_scan($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].en,
               EARLY ? tbl[i].grp_early : tbl[i].grp_full,
               EARLY ? tbl[i].edges_early : tbl[i].edges_full);
    end

    // Hold start during the scan with a different vector. That request must
    // be ignored until the controller returns to idle.
    exp_e    = EARLY ? 3 : 4;
    start_i  = 1'b1;
    vec_i    = bits2(70, -1);
    grp_en_i = 4'b1111;
    @(negedge clk);
    vec_i = ones;
    for (int i = 1; i <= exp_e; i++) begin
      @(negedge clk);
      check("busy_ign_done", 32'(done_o), 32'(i == exp_e));
    end
    check("busy_ign_hit_grp", 32'(hit_grp_o), 32'(4'b0100));
    @(negedge clk);
    check("busy_ign_idle", 32'(busy_o), 32'd0);
    check("busy_ign_single", 32'(done_o), 32'd0);
    check("busy_ign_hit", 32'(hit_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    vec_i   = '0;
    finish_scan("busy_ign_second", EARLY ? 4'b0001 : 4'b1111, EARLY ? 1 : 4);

    // Assert reset in the middle of a scan.
    start_i  = 1'b1;
    vec_i    = bits2(127, -1);
    grp_en_i = 4'b1111;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_idx", 32'(scan_idx_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_hit_grp", 32'(hit_grp_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done_o), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_stay_idle", 32'(busy_o), 32'd0);
    run_scan("midrst_fresh", bits2(127, -1), 4'b1111, 4'b1000, 4);

    // Randomized scans checked against the reference model.
    for (int it = 0; it < 40; it++) begin
      v = '0;
      for (int k = 0; k < NG; k++) begin
        case ($urandom_range(0, 3))
          0:       v[k*GW +: GW] = 32'd1 << $urandom_range(0, 31);
          1:       v[k*GW +: GW] = $urandom;
          default: v[k*GW +: GW] = '0;
        endcase
      end
      en = 4'($urandom_range(0, 15));
      model(v, en, g, edges);
      run_scan($sformatf("rnd%0d", it), v, en, g, edges);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
